// File: rtl/afu_pkg.sv
// Shared constants for the address/fetch slice of the 8-bit teaching CPU.
//   FunSel encodings (shared by ARF registers and the IR),
//   OutSel encodings for both ARF read ports,
//   bit positions of the per-register enables in ARF_RSel.
package afu_pkg;

  // Register function select
  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  // ARF output port select
  localparam logic [1:0] SEL_AR     = 2'b00;
  localparam logic [1:0] SEL_SP     = 2'b01;
  localparam logic [1:0] SEL_PCPAST = 2'b10;
  localparam logic [1:0] SEL_PC     = 2'b11;

  // Bit index of each register enable inside ARF_RSel
  localparam int RS_PCPAST = 0;
  localparam int RS_SP     = 1;
  localparam int RS_AR     = 2;
  localparam int RS_PC     = 3;

endpackage

// File: rtl/addr_fetch_unit_nbit_reg.sv
// Generic W-bit function register used for every ARF entry.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset (clears q, overrides enable)
//   enable   apply funsel this edge; otherwise hold
//   funsel   00 dec, 01 inc, 10 load din, 11 clear (inc/dec wrap mod 2^W)
//   din      load data
//   q        register contents
module nbit_reg
  import afu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [1:0]   funsel,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      case (funsel)
        FS_DEC:  q <= q - W'(1);
        FS_INC:  q <= q + W'(1);
        FS_LOAD: q <= din;
        FS_CLR:  q <= '0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/addr_fetch_unit.sv
// Address/fetch datapath slice: address register file (PC, AR, SP, PCpast),
// 2**ADDR_W x DATA_W data memory addressed by ARF_OutB, and a 2*DATA_W-bit
// instruction register loaded one byte at a time from memory.
// Ports:
//   Clock, Reset_n           rising-edge clock, synchronous active-low reset
//   ARF_In                   ARF load data
//   ARF_OutASel/ARF_OutBSel  read port selects (00 AR, 01 SP, 10 PCpast, 11 PC)
//   ARF_FunSel, ARF_RSel     ARF function and per-register enables
//   Mem_Data, Mem_WR, Mem_CS memory write data, 1=write, active-low select
//   IR_Funsel, IR_Enable     IR function and update enable
//   IR_LH                    IR load half (0 = low byte, 1 = high byte)
//   ARF_OutA, ARF_OutB       combinational ARF reads (OutB is the address)
//   Mem_Out                  asynchronous memory read data (0 unless reading)
//   IR_Out                   IR contents
module addr_fetch_unit
  import afu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [DATA_W-1:0]   ARF_In,
  input  logic [1:0]          ARF_OutASel,
  input  logic [1:0]          ARF_OutBSel,
  input  logic [1:0]          ARF_FunSel,
  input  logic [3:0]          ARF_RSel,
  input  logic [DATA_W-1:0]   Mem_Data,
  input  logic                Mem_WR,
  input  logic                Mem_CS,
  input  logic [1:0]          IR_Funsel,
  input  logic                IR_Enable,
  input  logic                IR_LH,
  output logic [DATA_W-1:0]   ARF_OutA,
  output logic [DATA_W-1:0]   ARF_OutB,
  output logic [DATA_W-1:0]   Mem_Out,
  output logic [2*DATA_W-1:0] IR_Out
);

  localparam int IR_W  = 2 * DATA_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] pc, ar, sp, pc_past;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ir_src;
  logic [IR_W-1:0]   ir;

  nbit_reg #(.W(DATA_W)) u_pc (
    .clock(Clock), .reset_n(Reset_n), .enable(ARF_RSel[RS_PC]),
    .funsel(ARF_FunSel), .din(ARF_In), .q(pc)
  );
  nbit_reg #(.W(DATA_W)) u_ar (
    .clock(Clock), .reset_n(Reset_n), .enable(ARF_RSel[RS_AR]),
    .funsel(ARF_FunSel), .din(ARF_In), .q(ar)
  );
  nbit_reg #(.W(DATA_W)) u_sp (
    .clock(Clock), .reset_n(Reset_n), .enable(ARF_RSel[RS_SP]),
    .funsel(ARF_FunSel), .din(ARF_In), .q(sp)
  );
  nbit_reg #(.W(DATA_W)) u_pc_past (
    .clock(Clock), .reset_n(Reset_n), .enable(ARF_RSel[RS_PCPAST]),
    .funsel(ARF_FunSel), .din(ARF_In), .q(pc_past)
  );

  always_comb begin
    ARF_OutA = ar;
    case (ARF_OutASel)
      SEL_AR:     ARF_OutA = ar;
      SEL_SP:     ARF_OutA = sp;
      SEL_PCPAST: ARF_OutA = pc_past;
      SEL_PC:     ARF_OutA = pc;
      default:    ARF_OutA = ar;
    endcase
  end

  always_comb begin
    ARF_OutB = ar;
    case (ARF_OutBSel)
      SEL_AR:     ARF_OutB = ar;
      SEL_SP:     ARF_OutB = sp;
      SEL_PCPAST: ARF_OutB = pc_past;
      SEL_PC:     ARF_OutB = pc;
      default:    ARF_OutB = ar;
    endcase
  end

  assign mem_addr = ARF_OutB[ADDR_W-1:0];

  // Write uses the pre-edge address; suppressed while reset is held.
  always_ff @(posedge Clock) begin
    if (Reset_n && !Mem_CS && Mem_WR) begin
      mem[mem_addr] <= Mem_Data;
    end
  end

  assign Mem_Out = (!Mem_CS && !Mem_WR) ? mem[mem_addr] : '0;

  // The IR sees the stored byte even during a same-edge write, so a
  // fetch-and-overwrite captures the old contents (read-before-write).
  assign ir_src = Mem_CS ? '0 : mem[mem_addr];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ir <= '0;
    end else if (IR_Enable) begin
      case (IR_Funsel)
        FS_DEC:  ir <= ir - IR_W'(1);
        FS_INC:  ir <= ir + IR_W'(1);
        FS_LOAD: begin
          if (IR_LH) ir[IR_W-1:DATA_W] <= ir_src;
          else       ir[DATA_W-1:0]    <= ir_src;
        end
        FS_CLR:  ir <= '0;
        default: ir <= ir;
      endcase
    end
  end

  assign IR_Out = ir;

endmodule

// File: tb/tb_addr_fetch_unit.sv
// Scoreboard bench for addr_fetch_unit: stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares them.
module tb_addr_fetch_unit;

  logic        Clock, Reset_n;
  logic [7:0]  ARF_In, Mem_Data;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel;
  logic [3:0]  ARF_RSel;
  logic        Mem_WR, Mem_CS, IR_Enable, IR_LH;
  logic [7:0]  ARF_OutA, ARF_OutB, Mem_Out;
  logic [15:0] IR_Out;

  addr_fetch_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ARF_In(ARF_In),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel), .Mem_Data(Mem_Data),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .IR_Funsel(IR_Funsel),
    .IR_Enable(IR_Enable), .IR_LH(IR_LH), .ARF_OutA(ARF_OutA),
    .ARF_OutB(ARF_OutB), .Mem_Out(Mem_Out), .IR_Out(IR_Out)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // sig: 0 = ARF_OutA, 1 = ARF_OutB, 2 = Mem_Out, 3 = IR_Out
  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_val(input string nm, input int sig, input logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.sig  = sig;
    e.exp  = v;
    sb.push_back(e);
  endtask

  always @(negedge Clock) begin
    exp_t        e;
    logic [15:0] act;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sig)
        0:       act = {8'h00, ARF_OutA};
        1:       act = {8'h00, ARF_OutB};
        2:       act = {8'h00, Mem_Out};
        default: act = IR_Out;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    ARF_RSel  = 4'b0000;
    IR_Enable = 1'b0;
    Mem_CS    = 1'b1;
    Mem_WR    = 1'b0;
    IR_LH     = 1'b0;
  endtask

  task automatic arf_op(input logic [3:0] rsel, input logic [1:0] fs, input logic [7:0] din);
    ARF_RSel   = rsel;
    ARF_FunSel = fs;
    ARF_In     = din;
    cyc();
    idle();
  endtask

  task automatic mem_write(input logic [7:0] d);
    Mem_Data = d;
    Mem_CS   = 1'b0;
    Mem_WR   = 1'b1;
    cyc();
    idle();
  endtask

  task automatic ir_op(input logic [1:0] fs, input logic lh);
    Mem_CS    = 1'b0;
    Mem_WR    = 1'b0;
    IR_Enable = 1'b1;
    IR_Funsel = fs;
    IR_LH     = lh;
    cyc();
    idle();
  endtask

  initial begin
    Reset_n = 1'b0; ARF_In = 8'h00; Mem_Data = 8'h00;
    ARF_OutASel = 2'b11; ARF_OutBSel = 2'b00; ARF_FunSel = 2'b00;
    IR_Funsel = 2'b00;
    idle();

    // Reset state
    cyc();
    expect_val("rst_pc_outa", 0, 16'h0000);
    expect_val("rst_ar_outb", 1, 16'h0000);
    expect_val("rst_ir", 3, 16'h0000);
    cyc();
    Reset_n = 1'b1;

    // ARF operations on AR; PC must hold
    arf_op(4'b0100, 2'b10, 8'h3C);
    ARF_OutASel = 2'b00; ARF_OutBSel = 2'b11;
    expect_val("ar_load", 0, 16'h003C);
    expect_val("pc_hold1", 1, 16'h0000);
    cyc();
    arf_op(4'b0100, 2'b01, 8'h00);
    arf_op(4'b0100, 2'b01, 8'h00);
    expect_val("ar_inc2", 0, 16'h003E);
    cyc();
    arf_op(4'b0100, 2'b11, 8'h00);
    arf_op(4'b0100, 2'b00, 8'h00);
    expect_val("ar_dec_wrap", 0, 16'h00FF);
    expect_val("pc_hold2", 1, 16'h0000);
    cyc();

    // Memory write / read / chip select
    arf_op(4'b0100, 2'b10, 8'h10);
    ARF_OutBSel = 2'b00;
    mem_write(8'hA5);
    Mem_CS = 1'b0; Mem_WR = 1'b0;
    expect_val("mem_rd", 2, 16'h00A5);
    cyc();
    Mem_CS = 1'b1; Mem_WR = 1'b0;
    expect_val("mem_cs_off", 2, 16'h0000);
    cyc();
    Mem_CS = 1'b1; Mem_WR = 1'b1; Mem_Data = 8'h5A;
    cyc();
    Mem_CS = 1'b0; Mem_WR = 1'b0;
    expect_val("mem_no_write", 2, 16'h00A5);
    cyc();
    idle();

    // IR fetch of two bytes
    mem_write(8'h12);
    arf_op(4'b0100, 2'b01, 8'h00);
    mem_write(8'h34);
    arf_op(4'b0100, 2'b10, 8'h10);
    ir_op(2'b10, 1'b0);
    arf_op(4'b0100, 2'b01, 8'h00);
    ir_op(2'b10, 1'b1);
    expect_val("ir_fetch", 3, 16'h3412);
    expect_val("ar_after_fetch", 0, 16'h0011);
    cyc();
    IR_Enable = 1'b0; IR_Funsel = 2'b11;
    cyc();
    expect_val("ir_hold", 3, 16'h3412);
    cyc();
    ir_op(2'b01, 1'b0);
    expect_val("ir_inc", 3, 16'h3413);
    cyc();
    ir_op(2'b00, 1'b0);
    ir_op(2'b00, 1'b0);
    expect_val("ir_dec", 3, 16'h3411);
    cyc();
    ir_op(2'b11, 1'b0);
    ir_op(2'b00, 1'b0);
    expect_val("ir_dec_wrap", 3, 16'hFFFF);
    cyc();
    ir_op(2'b01, 1'b0);
    expect_val("ir_inc_wrap", 3, 16'h0000);
    cyc();

    // Same-edge IR load and memory write: IR gets the old byte
    arf_op(4'b0100, 2'b10, 8'h20);
    mem_write(8'h11);
    Mem_Data = 8'h22; Mem_CS = 1'b0; Mem_WR = 1'b1;
    IR_Enable = 1'b1; IR_Funsel = 2'b10; IR_LH = 1'b0;
    cyc();
    idle();
    expect_val("ir_rbw", 3, 16'h0011);
    cyc();
    Mem_CS = 1'b0; Mem_WR = 1'b0;
    expect_val("mem_after_rbw", 2, 16'h0022);
    cyc();
    idle();

    // Same-edge AR increment and write: write lands at the pre-edge address
    Mem_Data = 8'h66; Mem_CS = 1'b0; Mem_WR = 1'b1;
    ARF_RSel = 4'b0100; ARF_FunSel = 2'b01;
    cyc();
    idle();
    arf_op(4'b0100, 2'b00, 8'h00);
    Mem_CS = 1'b0; Mem_WR = 1'b0;
    expect_val("mem_pre_edge_addr", 2, 16'h0066);
    cyc();
    idle();

    // Multiple registers selected at once
    arf_op(4'b0011, 2'b10, 8'h80);
    ARF_OutASel = 2'b01; ARF_OutBSel = 2'b10;
    expect_val("sp_multi", 0, 16'h0080);
    expect_val("pcpast_multi", 1, 16'h0080);
    cyc();

    // PC increment wrap
    arf_op(4'b1000, 2'b10, 8'hFF);
    arf_op(4'b1000, 2'b01, 8'h00);
    ARF_OutASel = 2'b11;
    expect_val("pc_inc_wrap", 0, 16'h0000);
    cyc();

    // Reset priority over ARF/IR/memory controls
    arf_op(4'b0100, 2'b11, 8'h00);
    ARF_OutBSel = 2'b00;
    mem_write(8'h77);
    ir_op(2'b01, 1'b0);
    Reset_n = 1'b0;
    ARF_RSel = 4'b1111; ARF_FunSel = 2'b10; ARF_In = 8'h55;
    Mem_CS = 1'b0; Mem_WR = 1'b1; Mem_Data = 8'h99;
    IR_Enable = 1'b1; IR_Funsel = 2'b01;
    cyc();
    Reset_n = 1'b1;
    idle();
    ARF_OutASel = 2'b11; ARF_OutBSel = 2'b01;
    expect_val("rstp_pc", 0, 16'h0000);
    expect_val("rstp_sp", 1, 16'h0000);
    expect_val("rstp_ir", 3, 16'h0000);
    cyc();
    ARF_OutASel = 2'b00; ARF_OutBSel = 2'b10;
    expect_val("rstp_ar", 0, 16'h0000);
    expect_val("rstp_pcpast", 1, 16'h0000);
    cyc();
    ARF_OutBSel = 2'b00; Mem_CS = 1'b0; Mem_WR = 1'b0;
    expect_val("rstp_mem0_kept", 2, 16'h0077);
    cyc();
    idle();

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge Clock);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: pending %0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
